// File: rtl/blink_sched_pkg.sv
// Shared types and helpers for the blink request scheduler.
// Holds the FSM state encoding and the round-robin next-grant search.
package blink_sched_pkg;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;
  localparam logic [1:0] STATE_GAP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_DONE = STATE_DONE,
    ST_GAP  = STATE_GAP
  } state_t;

  localparam int unsigned MAX_REQ = 8;

  // Walks upward from ptr+1 (wrapping at n) and returns the first set request.
  // Returns ptr unchanged when no request in range is set.
  function automatic logic [2:0] rr_next_index(input logic [7:0]   req,
                                               input logic [2:0]   ptr,
                                               input int unsigned  n);
    logic [2:0] cand;
    logic [2:0] idx;
    logic       found;
    cand  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        cand = (cand == 3'(n - 1)) ? 3'd0 : cand + 3'd1;
        if (!found && req[cand]) begin
          idx   = cand;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/blink_request_scheduler_timer.sv
// Shared half-period timebase: counts 0..COUNT_LIMIT-1 while enabled and
// flags the last count so the scheduler can act on the wrapping edge.
module half_period_timer #(
  parameter int COUNT_LIMIT = 10
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Wrap
);

  localparam int TW = (COUNT_LIMIT > 2) ? $clog2(COUNT_LIMIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(COUNT_LIMIT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;
  logic          at_last;

  assign at_last = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Enable) begin
      count_d = at_last ? '0 : count_q + TW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Clear wins over a coincident wrap so a restarted count never fires early.
  assign o_Wrap = i_Enable && !i_Clear && at_last;

endmodule

// File: rtl/blink_request_scheduler.sv
// Round-robin blink scheduler: one shared timer, bursts of NUM_BLINKS blinks
// per grant followed by a dark gap. Optional owner-drop abort: BLINK_SCHED_ABORT_EN.
module blink_request_scheduler
  import blink_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_LIMIT = 10,
  parameter int NUM_BLINKS  = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [NUM_REQ-1:0] i_Req,
  output logic [NUM_REQ-1:0] o_Grant,
  output logic [NUM_REQ-1:0] o_LED,
  output logic               o_Busy,
  output logic               o_Done
);

  localparam int BW = (NUM_BLINKS > 1) ? $clog2(NUM_BLINKS + 1) : 1;
  localparam logic [BW-1:0] LAST_BLINK = BW'(NUM_BLINKS - 1);
  localparam logic [BW-1:0] ALL_BLINKS = BW'(NUM_BLINKS);
  localparam logic [2:0]    PTR_RESET  = 3'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] led_q,   led_d;
  logic [2:0]         ptr_q,   ptr_d;
  logic [BW-1:0]      blinks_q, blinks_d;
  logic               toggle_q, toggle_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               timer_clear;
  logic               timer_enable;
  logic               timer_wrap;
  logic [2:0]         next_idx;
  logic [NUM_REQ-1:0] next_grant;
  logic               owner_req;

  assign next_idx   = rr_next_index(8'(i_Req), ptr_q, NUM_REQ);
  assign next_grant = NUM_REQ'(idx_to_onehot(next_idx));
  assign owner_req  = |(i_Req & grant_q);

  half_period_timer #(
    .COUNT_LIMIT (COUNT_LIMIT)
  ) u_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Clear  (timer_clear),
    .i_Enable (timer_enable),
    .o_Wrap   (timer_wrap)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    led_d        = led_q;
    ptr_d        = ptr_q;
    blinks_d     = blinks_q;
    toggle_d     = toggle_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_clear = 1'b1;
        if (|i_Req) begin
          grant_d  = next_grant;
          ptr_d    = next_idx;
          toggle_d = 1'b0;
          blinks_d = '0;
          led_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
`ifdef BLINK_SCHED_ABORT_EN
        if (!owner_req) begin
          // Owner let go: skip DONE, keep the pointer so fairness is unchanged.
          timer_clear = 1'b1;
          grant_d     = '0;
          led_d       = '0;
          toggle_d    = 1'b0;
          state_d     = ST_GAP;
        end else
`endif
        begin
          timer_enable = 1'b1;
          if (timer_wrap) begin
            toggle_d = !toggle_q;
            led_d    = toggle_q ? '0 : grant_q;
            if (toggle_q) begin
              if (blinks_q == LAST_BLINK) begin
                blinks_d = ALL_BLINKS;
                done_d   = 1'b1;
                state_d  = ST_DONE;
              end else begin
                blinks_d = blinks_q + BW'(1);
              end
            end
          end
        end
      end

      ST_DONE: begin
        timer_clear = 1'b1;
        grant_d     = '0;
        led_d       = '0;
        done_d      = 1'b0;
        state_d     = ST_GAP;
      end

      ST_GAP: begin
        timer_enable = 1'b1;
        if (timer_wrap) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      led_q    <= '0;
      ptr_q    <= PTR_RESET;
      blinks_q <= '0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      led_q    <= led_d;
      ptr_q    <= ptr_d;
      blinks_q <= blinks_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_Grant = grant_q;
  assign o_LED   = led_q;
  assign o_Busy  = busy_q;
  assign o_Done  = done_q;

`ifndef BLINK_SCHED_ABORT_EN
  logic unused_owner_req;
  assign unused_owner_req = owner_req;
`endif

endmodule

// File: tb/tb_blink_request_scheduler.sv
// Directed bench for blink_request_scheduler with COUNT_LIMIT=4, NUM_BLINKS=2.
// Abort checks follow BLINK_SCHED_ABORT_EN when it is defined for the build.
module tb_blink_request_scheduler;

  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] grant;
  logic [NR-1:0] led;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  blink_request_scheduler #(
    .NUM_REQ     (NR),
    .COUNT_LIMIT (4),
    .NUM_BLINKS  (2)
  ) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Req   (req),
    .o_Grant (grant),
    .o_LED   (led),
    .o_Busy  (busy),
    .o_Done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] led;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      chk("led_owner_only", 32'(led & ~grant), 32'd0);
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic setv(input int k, input logic [3:0] r, input logic [3:0] g,
                      input logic [3:0] l, input logic b, input logic d);
    tv[k] = '{req: r, grant: g, led: l, busy: b, done: d};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;

    // Row k holds the outputs seen after edge T+k (T = request sample edge).
    setv( 0, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv( 1, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv( 2, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv( 3, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv( 4, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv( 5, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv( 6, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv( 7, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv( 8, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv( 9, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv(10, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv(11, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    setv(12, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv(13, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv(14, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv(15, 4'b0001, 4'b0001, 4'b0001, 1, 0);
    setv(16, 4'b0001, 4'b0001, 4'b0000, 1, 1);
    setv(17, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    setv(18, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    setv(19, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    setv(20, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    setv(21, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    rst = 1'b1;
    req = '0;
    step();
    step();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_led",   32'(led),   32'd0);
    chk("reset_busy",  32'(busy),  32'd0);
    chk("reset_done",  32'(done),  32'd0);
    rst = 1'b0;
    step();

    // Single request burst, table driven.
    for (int k = 0; k < 22; k++) begin
      req = tv[k].req;
      step();
      $display("vec %0d req=%b grant=%b led=%b busy=%b done=%b", k, req, grant, led, busy, done);
      chk($sformatf("vec%0d_grant", k), 32'(grant), 32'(tv[k].grant));
      chk($sformatf("vec%0d_led", k),   32'(led),   32'(tv[k].led));
      chk($sformatf("vec%0d_busy", k),  32'(busy),  32'(tv[k].busy));
      chk($sformatf("vec%0d_done", k),  32'(done),  32'(tv[k].done));
    end

    // Round-robin fairness with all requests held.
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (b % 4);
      wait_grant(ok);
      chk($sformatf("rr%0d_grant_seen", b), 32'(ok), 32'd1);
      $display("rr burst %0d grant=%b", b, grant);
      chk($sformatf("rr%0d_grant", b), 32'(grant), 32'(exp_g));
      if (b < 4) begin
        wait_done(ok);
        chk($sformatf("rr%0d_done_seen", b), 32'(ok), 32'd1);
      end
    end

    // Late arrivals: req[2] during GAP, req[1] in IDLE at the grant edge.
    do_reset();
    req = 4'b0001;
    step();
    chk("late_first_grant", 32'(grant), 32'b0001);
    for (int k = 1; k <= 16; k++) step();
    chk("late_done_t16", 32'(done), 32'd1);
    req = 4'b0000;
    step();
    step();
    req = 4'b0100;
    step();
    step();
    step();
    chk("late_gap_not_latched_grant", 32'(grant), 32'd0);
    chk("late_idle_busy", 32'(busy), 32'd0);
    req = 4'b0110;
    step();
    $display("late arrival grant=%b", grant);
    chk("late_second_grant", 32'(grant), 32'b0010);
    wait_done(ok);
    chk("late_second_done_seen", 32'(ok), 32'd1);
    req = 4'b0100;
    wait_grant(ok);
    chk("late_third_grant_seen", 32'(ok), 32'd1);
    chk("late_third_grant", 32'(grant), 32'b0100);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    req = 4'b1111;
    step();
    chk("arst_pre_grant", 32'(grant), 32'b0001);
    for (int k = 1; k <= 5; k++) step();
    chk("arst_pre_led", 32'(led), 32'b0001);
    rst = 1'b1;
    #1;
    $display("async reset grant=%b led=%b busy=%b done=%b", grant, led, busy, done);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_led",   32'(led),   32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(done),  32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_after_grant", 32'(grant), 32'b0001);
    chk("arst_after_busy",  32'(busy),  32'd1);

    // Owner drops its request at T+5.
    do_reset();
    req = 4'b0001;
    step();
    chk("drop_grant_t0", 32'(grant), 32'b0001);
    for (int k = 1; k <= 4; k++) step();
    chk("drop_led_t4", 32'(led), 32'b0001);
    req = 4'b0000;
    step();
`ifdef BLINK_SCHED_ABORT_EN
    $display("abort t5 grant=%b led=%b busy=%b done=%b", grant, led, busy, done);
    chk("abort_grant_t5", 32'(grant), 32'd0);
    chk("abort_led_t5",   32'(led),   32'd0);
    chk("abort_busy_t5",  32'(busy),  32'd1);
    chk("abort_done_t5",  32'(done),  32'd0);
    for (int k = 6; k <= 8; k++) begin
      step();
      chk($sformatf("abort_done_t%0d", k), 32'(done), 32'd0);
    end
    chk("abort_busy_t8", 32'(busy), 32'd1);
    step();
    chk("abort_busy_t9", 32'(busy), 32'd0);
`else
    for (int k = 5; k < 16; k++) begin
      chk($sformatf("noabort_done_t%0d", k), 32'(done), 32'd0);
      chk($sformatf("noabort_grant_t%0d", k), 32'(grant), 32'b0001);
      step();
    end
    $display("no abort t16 grant=%b led=%b busy=%b done=%b", grant, led, busy, done);
    chk("noabort_done_t16", 32'(done), 32'd1);
    chk("noabort_grant_t16", 32'(grant), 32'b0001);
    step();
    chk("noabort_grant_t17", 32'(grant), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
